// File: rtl/dff_arb_pkg.sv
// Shared types and constants for the two-client register arbiter.
// Holds the FSM state enum, default sizes and client indices.
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    localparam logic C0 = 1'b0;
    localparam logic C1 = 1'b1;

    // One-hot vector for a client index.
    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dff_reg.sv
// WIDTH-bit bank of D flip-flops with a load-enable mux.
// Ports: clk_i, clear_i (sync active-low), en_i, d_i, q_o.
module dff_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] d_mux;
    logic [WIDTH-1:0] bits_q;

    // Recirculate the stored bit when not loading.
    assign d_mux = en_i ? d_i : bits_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        always_ff @(posedge clk_i) begin
            if (!clear_i) begin
                bits_q[i] <= 1'b0;
            end else begin
                bits_q[i] <= d_mux[i];
            end
        end
    end

    assign q_o = bits_q;

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter serialising two write clients onto one register.
// Ports: clk, clear (sync active-low), req, wdata0/1 in; gnt, ack, q, busy, wcount out.
module dff_reg_arbiter
    import dff_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [1:0]       gnt,
    output logic [1:0]       ack,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic [CNT_W-1:0] wcount
);

    arb_state_e       state_q;
    logic             sel_q;
    logic             sel_d;
    logic             ptr_q;
    logic [1:0]       gnt_q;
    logic [1:0]       ack_q;
    logic             busy_q;
    logic [CNT_W-1:0] wcount_q;
    logic [CNT_W-1:0] wcount_d;
    logic [WIDTH-1:0] wdata_sel;
    logic             cap_en;

    // Winner among current requests; ptr breaks a tie.
    always_comb begin
        sel_d = C0;
        unique case (req)
            2'b01:   sel_d = C0;
            2'b10:   sel_d = C1;
            2'b11:   sel_d = ptr_q;
            default: sel_d = C0;
        endcase
    end

    assign wcount_d  = wcount_q + CNT_W'(1);
    assign wdata_sel = sel_q ? wdata1 : wdata0;
    assign cap_en    = (state_q == GRANT);

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q  <= IDLE;
            sel_q    <= C0;
            ptr_q    <= C0;
            gnt_q    <= 2'b00;
            ack_q    <= 2'b00;
            busy_q   <= 1'b0;
            wcount_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        sel_q   <= sel_d;
                        gnt_q   <= onehot(sel_d);
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    ack_q    <= onehot(sel_q);
                    wcount_q <= wcount_d;
                    state_q  <= ACK;
                end
                ACK: begin
                    ack_q   <= 2'b00;
                    // Advance even on an uncontested grant.
                    ptr_q   <= ~sel_q;
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!req[sel_q]) begin
                        gnt_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dff_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk_i   (clk),
        .clear_i (clear),
        .en_i    (cap_en),
        .d_i     (wdata_sel),
        .q_o     (q)
    );

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign busy   = busy_q;
    assign wcount = wcount_q;

endmodule

// File: doc/dff_reg_arbiter.md
# dff_reg_arbiter

- Two-requester round-robin arbiter that shares one WIDTH-bit storage register between two write clients.
- The register is built from the team's D_FF cells.
- The block serialises writes, reports which client owns the register, and acknowledges each write after the data is stored.
- It sits between the producer logic and the shared D_FF register bank.

## Interface

Parameters:
- WIDTH, 8, data width of the shared register and of each write port.
- CNT_W, 8, width of the completed-write counter.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- clear  input  1  reset, synchronous and active-low.
- req  input  2  write request per client; level, held until ack is seen.
- wdata0  input  WIDTH  client 0 write data; stable from req[0] rise until ack[0].
- wdata1  input  WIDTH  client 1 write data; same rule.
- gnt  output  2  one-hot owner of the register; 2'b00 when idle.
- ack  output  2  one-cycle pulse: write of that client is stored in q.
- q  output  WIDTH  current shared register contents.
- busy  output  1  high whenever the FSM is not in IDLE.
- wcount  output  CNT_W  number of completed writes, wraps modulo 2^CNT_W.

## Operation

- **Reset:** clear=0 at a rising edge forces:
  - state=IDLE, gnt=0, ack=0, q=0, busy=0, wcount=0, ptr=0.
- **ptr:** 1-bit priority pointer; 0 means client 0 wins a tie. It is internal and not exported.
- **FSM states:** IDLE, GRANT, ACK, RELEASE. All outputs are registered.
- **IDLE:**
  - req=00: stay.
  - Exactly one req bit set: that client is selected (sel).
  - Both bits set: sel=ptr.
  - Next state GRANT; gnt[sel]=1.
- **GRANT:**
  - q <= wdata[sel] through the register enable.
  - wcount <= wcount+1.
  - Next state ACK; ack[sel]=1.
- **ACK:**
  - ack cleared.
  - ptr <= ~sel.
  - Next state RELEASE.
- **RELEASE:**
  - Stay while req[sel]=1.
  - When req[sel]=0: gnt cleared, next state IDLE.
- **Pointer rule:** the pointer advances after every grant, even an uncontested one. Strict alternation therefore holds under continuous contention.
- **Early req drop:** if req[sel] drops before ack, the transaction still completes. Data is captured in GRANT regardless, and ack is still pulsed.
- **req during busy:** ignored; sampled again only in IDLE.
- **Register hold:** q holds its value in every cycle except the GRANT capture cycle.
- **Reset mid-operation:** the synchronous reset dominates all transitions. An in-flight write is lost, q=0, and no ack is issued.
- **wcount wrap:** 2^CNT_W−1 followed by a capture gives 0; no flag.

## Timing

- **Edge k** (IDLE, req≠0 sampled): gnt visible after edge k; busy=1.
- **Edge k+1:** q holds the new data; ack[sel]=1 during cycle k+1..k+2.
- **Edge k+2:** ack=0.
- **RELEASE exit:** earliest exit is edge k+3 if req[sel] is already low, giving gnt=0 and busy=0 after k+3.
- **Turnaround:** minimum 4 cycles per write; earliest next grant at edge k+4.
- **Latency:** request-to-data 2 edges; request-to-ack 2 edges.
- **gnt:** stable and one-hot from edge k to RELEASE exit.
- **ack:** never high for both clients; never high for more than one cycle per transaction.

## Structure

- **Package dff_arb_pkg:**
  - state enum {IDLE, GRANT, ACK, RELEASE}, 2-bit encoding 0..3.
  - Default WIDTH and CNT_W constants.
  - Client index constants C0=0, C1=1.
- **Sub-module dff_reg:**
  - WIDTH-bit bank of D_FF cells plus a load-enable mux.
  - Synchronous active-low clear.
  - Instantiated once for q.
- **Top level holds:** FSM, ptr, sel register, wdata mux, wcount.

## Test plan

- **Reset:** clear=0 for 2 edges with req=11 and wdata nonzero → q=0, gnt=00, ack=00, busy=0, wcount=0.
- **Single write:** req=01, wdata0=8'hA5 → gnt=01 after edge k, q=A5 and ack=01 after k+1, ack=00 after k+2. Drop req → gnt=00 after the next edge; wcount=1.
- **Contention:**
  - req=11, wdata0=8'h11, wdata1=8'h22, each client dropping req one cycle after its ack.
  - Grants 0 then 1 then 0; q sequence 11, 22, 11.
  - ack pulses never overlap.
- **Pointer after uncontested grant:** single write by client 0, then req=11 → client 1 granted first.
- **Reset mid-operation:** clear=0 in the GRANT cycle with wdata1=8'hFF → after the edge, q=0, no ack pulse, state IDLE, wcount unchanged at 0.
- **Counter wrap:** CNT_W=2, five writes → wcount sequence 1, 2, 3, 0, 1.
